// File: rtl/uart_cmd_decode.sv
`default_nettype none
// ============================================================================
// Module   : uart_cmd_decode
// Brief    : Parses UART rx bytes into SDRAM write-FIFO pushes and
//            write/read triggers, with an inter-byte timeout abort.
// Revision : 1.0 - initial release
// ============================================================================
module uart_cmd_decode #(
    parameter logic [7:0] WR_HDR      = 8'h55,
    parameter logic [7:0] RD_HDR      = 8'hAA,
    parameter int         WR_LEN      = 4,
    parameter int         TIMEOUT_CYC = 500000
) (
    input  logic       sclk,
    input  logic       s_rst_n,
    input  logic       uart_flag,
    input  logic [7:0] uart_data,
    output logic       wfifo_wr_en,
    output logic [7:0] wfifo_data,
    output logic       wfifo_clr,
    output logic       wr_trig,
    output logic       rd_trig,
    output logic       cmd_err,
    output logic       busy
);

    localparam int               c_TO_W      = $clog2(TIMEOUT_CYC + 1);
    localparam logic [7:0]       c_LAST_BYTE = 8'(WR_LEN - 1);
    localparam logic [c_TO_W-1:0] c_TO_LAST  = c_TO_W'(TIMEOUT_CYC - 1);

    localparam logic [0:0] S_IDLE    = 1'b0;
    localparam logic [0:0] S_WR_DATA = 1'b1;

    logic [0:0]        r_state,     w_state_nxt;
    logic [7:0]        r_byte_cnt,  w_byte_cnt_nxt;
    logic [c_TO_W-1:0] r_to_cnt,    w_to_cnt_nxt;
    logic              r_wr_en,     w_wr_en_nxt;
    logic [7:0]        r_data,      w_data_nxt;
    logic              r_clr,       w_clr_nxt;
    logic              r_trig_pend, w_trig_pend_nxt;
    logic              r_wr_trig;
    logic              r_rd_trig,   w_rd_trig_nxt;
    logic              r_err,       w_err_nxt;

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            r_state     <= S_IDLE;
            r_byte_cnt  <= 8'd0;
            r_to_cnt    <= '0;
            r_wr_en     <= 1'b0;
            r_data      <= 8'h00;
            r_clr       <= 1'b0;
            r_trig_pend <= 1'b0;
            r_wr_trig   <= 1'b0;
            r_rd_trig   <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_byte_cnt  <= w_byte_cnt_nxt;
            r_to_cnt    <= w_to_cnt_nxt;
            r_wr_en     <= w_wr_en_nxt;
            r_data      <= w_data_nxt;
            r_clr       <= w_clr_nxt;
            r_trig_pend <= w_trig_pend_nxt;
            // write trigger trails the final push by one cycle so the FIFO holds all bytes
            r_wr_trig   <= r_trig_pend;
            r_rd_trig   <= w_rd_trig_nxt;
            r_err       <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_byte_cnt_nxt  = r_byte_cnt;
        w_to_cnt_nxt    = r_to_cnt;
        w_wr_en_nxt     = 1'b0;
        w_data_nxt      = r_data;
        w_clr_nxt       = 1'b0;
        w_trig_pend_nxt = 1'b0;
        w_rd_trig_nxt   = 1'b0;
        w_err_nxt       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (uart_flag) begin
                    if (uart_data == WR_HDR) begin
                        w_state_nxt    = S_WR_DATA;
                        w_byte_cnt_nxt = 8'd0;
                        w_to_cnt_nxt   = '0;
                    end else if (uart_data == RD_HDR) begin
                        w_rd_trig_nxt = 1'b1;
                    end
                end
            end
            S_WR_DATA: begin
                // an arriving byte takes priority over the timeout terminal count
                if (uart_flag) begin
                    w_wr_en_nxt  = 1'b1;
                    w_data_nxt   = uart_data;
                    w_to_cnt_nxt = '0;
                    if (r_byte_cnt == c_LAST_BYTE) begin
                        w_state_nxt     = S_IDLE;
                        w_byte_cnt_nxt  = 8'd0;
                        w_trig_pend_nxt = 1'b1;
                    end else begin
                        w_byte_cnt_nxt = r_byte_cnt + 8'd1;
                    end
                end else if (r_to_cnt == c_TO_LAST) begin
                    w_state_nxt    = S_IDLE;
                    w_byte_cnt_nxt = 8'd0;
                    w_to_cnt_nxt   = '0;
                    w_err_nxt      = 1'b1;
                    w_clr_nxt      = 1'b1;
                end else begin
                    w_to_cnt_nxt = r_to_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign wfifo_wr_en = r_wr_en;
    assign wfifo_data  = r_data;
    assign wfifo_clr   = r_clr;
    assign wr_trig     = r_wr_trig;
    assign rd_trig     = r_rd_trig;
    assign cmd_err     = r_err;
    assign busy        = (r_state == S_WR_DATA);

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_decode.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_cmd_decode
// Brief    : Directed and randomized bench for uart_cmd_decode against a
//            packet-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_cmd_decode;

    localparam int c_TO  = 100;
    localparam int c_LEN = 4;

    logic       sclk = 1'b0;
    logic       s_rst_n = 1'b0;
    logic       uart_flag = 1'b0;
    logic [7:0] uart_data = 8'h00;
    logic       wfifo_wr_en, wfifo_clr, wr_trig, rd_trig, cmd_err, busy;
    logic [7:0] wfifo_data;

    uart_cmd_decode #(
        .WR_HDR(8'h55), .RD_HDR(8'hAA), .WR_LEN(c_LEN), .TIMEOUT_CYC(c_TO)
    ) u_dut (
        .sclk(sclk), .s_rst_n(s_rst_n), .uart_flag(uart_flag), .uart_data(uart_data),
        .wfifo_wr_en(wfifo_wr_en), .wfifo_data(wfifo_data), .wfifo_clr(wfifo_clr),
        .wr_trig(wr_trig), .rd_trig(rd_trig), .cmd_err(cmd_err), .busy(busy)
    );

    always #5 sclk = ~sclk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: packet view (collecting flag, bytes received, silent cycles)
    bit       m_collect = 0;
    int       m_got = 0;
    int       m_silent = 0;
    bit       m_trig_due = 0;
    bit       e_wr_en = 0, e_clr = 0, e_trig = 0, e_rd = 0, e_err = 0, e_busy = 0;
    bit [7:0] e_data = 8'h00;

    always @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            m_collect = 0; m_got = 0; m_silent = 0; m_trig_due = 0;
            e_wr_en = 0; e_clr = 0; e_trig = 0; e_rd = 0; e_err = 0; e_busy = 0;
            e_data = 8'h00;
        end else begin
            e_trig = m_trig_due;
            m_trig_due = 0;
            e_wr_en = 0; e_clr = 0; e_rd = 0; e_err = 0;
            if (!m_collect) begin
                if (uart_flag && uart_data == 8'h55) begin
                    m_collect = 1; m_got = 0; m_silent = 0;
                end else if (uart_flag && uart_data == 8'hAA) begin
                    e_rd = 1;
                end
            end else if (uart_flag) begin
                e_wr_en = 1; e_data = uart_data; m_got++; m_silent = 0;
                if (m_got == c_LEN) begin
                    m_collect = 0; m_trig_due = 1;
                end
            end else begin
                m_silent++;
                if (m_silent == c_TO) begin
                    m_collect = 0; e_err = 1; e_clr = 1;
                end
            end
            e_busy = m_collect;
        end
    end

    // Pulse counters and push log used by the directed literal checks
    int       cnt_wr = 0, cnt_trig = 0, cnt_rd = 0, cnt_err = 0, cnt_clr = 0;
    logic [7:0] push_log[$];

    always @(negedge sclk) begin
        if (wfifo_wr_en) begin cnt_wr++; push_log.push_back(wfifo_data); end
        if (wr_trig) cnt_trig++;
        if (rd_trig) cnt_rd++;
        if (cmd_err) cnt_err++;
        if (wfifo_clr) cnt_clr++;
        chk("wfifo_wr_en", int'(wfifo_wr_en), int'(e_wr_en));
        chk("wfifo_data", int'(wfifo_data), int'(e_data));
        chk("wfifo_clr", int'(wfifo_clr), int'(e_clr));
        chk("wr_trig", int'(wr_trig), int'(e_trig));
        chk("rd_trig", int'(rd_trig), int'(e_rd));
        chk("cmd_err", int'(cmd_err), int'(e_err));
        chk("busy", int'(busy), int'(e_busy));
    end

    int b_wr, b_trig, b_rd, b_err, b_clr, b_log;
    logic [7:0] tx_q[$];
    logic [7:0] exp_q[$];

    task automatic mark();
        b_wr = cnt_wr; b_trig = cnt_trig; b_rd = cnt_rd;
        b_err = cnt_err; b_clr = cnt_clr; b_log = push_log.size();
    endtask

    task automatic expect_counts(input string name, input int wr, input int trig,
                                 input int rd, input int err, input int clr);
        chk({name, "_pushes"}, cnt_wr - b_wr, wr);
        chk({name, "_wr_trig"}, cnt_trig - b_trig, trig);
        chk({name, "_rd_trig"}, cnt_rd - b_rd, rd);
        chk({name, "_cmd_err"}, cnt_err - b_err, err);
        chk({name, "_clr"}, cnt_clr - b_clr, clr);
    endtask

    task automatic expect_log(input string name);
        for (int k = 0; k < exp_q.size(); k++) begin
            if (b_log + k < push_log.size())
                chk({name, "_data"}, int'(push_log[b_log + k]), int'(exp_q[k]));
            else
                chk({name, "_data_missing"}, 1, 0);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge sclk);
    endtask

    task automatic pulse(input logic [7:0] b);
        @(posedge sclk); #2;
        uart_flag = 1'b1; uart_data = b;
        @(posedge sclk); #2;
        uart_flag = 1'b0;
    endtask

    task automatic send_q(input bit b2b);
        if (b2b) begin
            @(posedge sclk); #2;
            uart_flag = 1'b1;
            foreach (tx_q[k]) begin
                uart_data = tx_q[k];
                @(posedge sclk); #2;
            end
            uart_flag = 1'b0;
        end else begin
            foreach (tx_q[k]) begin
                pulse(tx_q[k]);
                idle(3);
            end
        end
    endtask

    initial begin
        int r, silence;
        #13;
        chk("reset_busy", int'(busy), 0);
        chk("reset_wr_en", int'(wfifo_wr_en), 0);
        chk("reset_data", int'(wfifo_data), 0);
        @(posedge sclk); #2;
        s_rst_n = 1'b1;
        idle(2);

        // write packet
        mark();
        tx_q = '{8'h55, 8'h11, 8'h22, 8'h33, 8'h44};
        send_q(0);
        idle(3);
        exp_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        expect_counts("t1", 4, 1, 0, 0, 0);
        expect_log("t1");
        chk("t1_busy_after", int'(busy), 0);

        // read command
        mark();
        pulse(8'hAA);
        idle(3);
        expect_counts("t2", 0, 0, 1, 0, 0);

        // junk then write
        mark();
        tx_q = '{8'h00, 8'hFF, 8'hAB};
        send_q(0);
        idle(2);
        expect_counts("t3_junk", 0, 0, 0, 0, 0);
        mark();
        tx_q = '{8'h55, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        send_q(0);
        idle(3);
        exp_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        expect_counts("t3", 4, 1, 0, 0, 0);
        expect_log("t3");

        // timeout abort then fresh packet
        mark();
        tx_q = '{8'h55, 8'h01, 8'h02};
        send_q(0);
        idle(c_TO + 5);
        expect_counts("t4_abort", 2, 0, 0, 1, 1);
        chk("t4_busy", int'(busy), 0);
        mark();
        tx_q = '{8'h55, 8'h05, 8'h06, 8'h07, 8'h08};
        send_q(0);
        idle(3);
        exp_q = '{8'h05, 8'h06, 8'h07, 8'h08};
        expect_counts("t4", 4, 1, 0, 0, 0);
        expect_log("t4");

        // headers as payload, consecutive-cycle flags
        mark();
        tx_q = '{8'h55, 8'hAA, 8'h55, 8'hAA, 8'h55};
        send_q(1);
        idle(3);
        exp_q = '{8'hAA, 8'h55, 8'hAA, 8'h55};
        expect_counts("t5", 4, 1, 0, 0, 0);
        expect_log("t5");

        // header right after final payload byte is decoded
        mark();
        tx_q = '{8'h55, 8'h10, 8'h20, 8'h30, 8'h40, 8'hAA};
        send_q(1);
        idle(3);
        expect_counts("t5b", 4, 1, 1, 0, 0);

        // reset mid-packet
        mark();
        pulse(8'h55);
        pulse(8'h01);
        idle(1);
        chk("t6_busy_before", int'(busy), 1);
        #1 s_rst_n = 1'b0;
        #1;
        chk("t6_busy_rst", int'(busy), 0);
        chk("t6_wr_en_rst", int'(wfifo_wr_en), 0);
        chk("t6_data_rst", int'(wfifo_data), 0);
        idle(2);
        #2 s_rst_n = 1'b1;
        pulse(8'hAA);
        idle(c_TO + 5);
        expect_counts("t6", 1, 0, 1, 0, 0);

        // flag on the exact timeout cycle wins
        mark();
        pulse(8'h55);
        idle(c_TO - 2);
        pulse(8'h77);
        tx_q = '{8'h78, 8'h79, 8'h7A};
        send_q(0);
        idle(3);
        exp_q = '{8'h77, 8'h78, 8'h79, 8'h7A};
        expect_counts("t7", 4, 1, 0, 0, 0);
        expect_log("t7");

        // randomized stream, model checks every cycle
        silence = 0;
        for (int i = 0; i < 6000; i++) begin
            @(posedge sclk); #2;
            r = $urandom_range(0, 99);
            if (silence > 0) begin
                uart_flag = 1'b0;
                silence--;
            end else if (r < 30) begin
                uart_flag = 1'b1;
                case ($urandom_range(0, 3))
                    0: uart_data = 8'h55;
                    1: uart_data = 8'hAA;
                    default: uart_data = 8'($urandom_range(0, 255));
                endcase
            end else begin
                uart_flag = 1'b0;
                if (r >= 98) silence = $urandom_range(c_TO - 3, c_TO + 3);
            end
        end
        @(posedge sclk); #2;
        uart_flag = 1'b0;
        idle(c_TO + 5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
